// File: rtl/filter_sched_pkg.sv
// Shared helpers for the multi-channel boxcar scheduler: index sizing and
// elaboration-time width checks.
package filter_sched_pkg;

   localparam int unsigned MinOrder    = 2;
   localparam int unsigned MinChannels = 2;

   // Channel index width; a single-bit index is kept even for degenerate counts.
   function automatic int unsigned ch_idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic bit width_ok(input int unsigned in_w,
                                   input int unsigned out_w,
                                   input int unsigned order);
      return out_w >= in_w + $clog2(order);
   endfunction

   function automatic int unsigned cnt_w(input int unsigned order);
      return $clog2(order + 1);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first request at or above the pointer,
// wrapping; the pointer moves past the winner when advance_i is strobed.
module rr_arbiter
   import filter_sched_pkg::*;
#(
   parameter int unsigned CHANNELS = 4
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic                              clear_i,
   input  logic                              enable_i,
   input  logic                              advance_i,
   input  logic [CHANNELS-1:0]               req_i,
   output logic [CHANNELS-1:0]               grant_o,
   output logic [ch_idx_w(CHANNELS)-1:0]     grant_idx_o
);

   localparam int unsigned IdxW = ch_idx_w(CHANNELS);

   logic [IdxW-1:0] ptr_q, ptr_d;
   logic            found;

   always_comb begin
      int unsigned c;
      grant_o     = '0;
      grant_idx_o = '0;
      found       = 1'b0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         c = int'(ptr_q) + i;
         if (c >= CHANNELS) c = c - CHANNELS;
         if (!found && enable_i && req_i[c]) begin
            found       = 1'b1;
            grant_o[c]  = 1'b1;
            grant_idx_o = IdxW'(c);
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (advance_i) begin
         ptr_d = (grant_idx_o == IdxW'(CHANNELS - 1)) ? '0 : grant_idx_o + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni || clear_i) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/filter_ch_scheduler.sv
// Time-shared moving-average filter: one boxcar datapath serving CHANNELS
// streams through a round-robin arbiter, results tagged by channel.
module filter_ch_scheduler
   import filter_sched_pkg::*;
#(
   parameter int unsigned INPUT_WIDTH  = 16,
   parameter int unsigned OUTPUT_WIDTH = 18,
   parameter int unsigned ORDER        = 4,
   parameter int unsigned CHANNELS     = 4
) (
   input  logic                              clk,
   input  logic                              nrst,
   input  logic                              flush,
   input  logic [CHANNELS-1:0]               in_valid,
   input  logic [CHANNELS*INPUT_WIDTH-1:0]   in_data,
   output logic [CHANNELS-1:0]               in_ready,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [ch_idx_w(CHANNELS)-1:0]     out_ch,
   output logic [OUTPUT_WIDTH-1:0]           out_result,
   output logic                              out_warm
);

   localparam int unsigned ChW  = ch_idx_w(CHANNELS);
   localparam int unsigned CntW = cnt_w(ORDER);

   if (!width_ok(INPUT_WIDTH, OUTPUT_WIDTH, ORDER)) begin : g_bad_width
      $error("OUTPUT_WIDTH too narrow for INPUT_WIDTH and ORDER");
   end
   if (ORDER < MinOrder) begin : g_bad_order
      $error("ORDER must be at least 2");
   end
   if (CHANNELS < MinChannels) begin : g_bad_channels
      $error("CHANNELS must be at least 2");
   end

   // hist[0] is the newest sample, hist[ORDER-1] the one about to drop out.
   typedef struct packed {
      logic [ORDER-1:0][INPUT_WIDTH-1:0] hist;
      logic [OUTPUT_WIDTH-1:0]           sum;
      logic [CntW-1:0]                   cnt;
   } ch_state_t;

   ch_state_t               st_q [CHANNELS];
   ch_state_t               cur_st, new_st;

   logic                    out_valid_q;
   logic [ChW-1:0]          out_ch_q;
   logic [OUTPUT_WIDTH-1:0] out_result_q;
   logic                    out_warm_q;

   logic                    stall, enable, accept;
   logic [CHANNELS-1:0]     grant;
   logic [ChW-1:0]          gidx;
   logic [INPUT_WIDTH-1:0]  sample;

   assign stall  = out_valid_q && !out_ready;
   assign enable = nrst && !flush && !stall;
   assign accept = |grant;

   rr_arbiter #(
      .CHANNELS (CHANNELS)
   ) u_arb (
      .clk_i       (clk),
      .rst_ni      (nrst),
      .clear_i     (flush),
      .enable_i    (enable),
      .advance_i   (accept),
      .req_i       (in_valid),
      .grant_o     (grant),
      .grant_idx_o (gidx)
   );

   assign sample = in_data[int'(gidx)*INPUT_WIDTH +: INPUT_WIDTH];

   always_comb begin
      cur_st      = st_q[gidx];
      new_st      = cur_st;
      new_st.hist = {cur_st.hist[ORDER-2:0], sample};
      // Subtract before add keeps the intermediate within the running-sum range.
      new_st.sum  = cur_st.sum - OUTPUT_WIDTH'(cur_st.hist[ORDER-1]) + OUTPUT_WIDTH'(sample);
      new_st.cnt  = (cur_st.cnt == CntW'(ORDER)) ? cur_st.cnt : cur_st.cnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!nrst || flush) begin
         for (int k = 0; k < CHANNELS; k++) begin
            st_q[k] <= '0;
         end
         out_valid_q  <= 1'b0;
         out_ch_q     <= '0;
         out_result_q <= '0;
         out_warm_q   <= 1'b0;
      end else if (accept) begin
         st_q[gidx]   <= new_st;
         out_valid_q  <= 1'b1;
         out_ch_q     <= gidx;
         out_result_q <= new_st.sum;
         out_warm_q   <= (new_st.cnt == CntW'(ORDER));
      end else if (!stall) begin
         out_valid_q  <= 1'b0;
      end
   end

   assign in_ready   = grant;
   assign out_valid  = out_valid_q;
   assign out_ch     = out_ch_q;
   assign out_result = out_result_q;
   assign out_warm   = out_warm_q;

endmodule
